// File: rtl/seq_det_pkg.sv
// Shared types and constants for the sequence-detector match window counter.
// Holds the FSM state encoding, default sizing and the counter-width rule.
package seq_det_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  localparam int unsigned DEF_WINDOW = 16;
  localparam int unsigned DEF_THRESH = 4;

  // Counters must hold the value WINDOW itself (every bit of a window matched).
  function automatic int unsigned cnt_width(input int unsigned window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/seq_rec_hold.sv
// Single-entry valid/ready hold register. A load while an unaccepted entry is
// held keeps the old entry and pulses drop for the caller to record.
module seq_rec_hold #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         drop
);

  logic accept;
  assign accept = valid && ready;

  // An entry is lost only when one is held and the consumer is not taking it.
  assign drop = load && valid && !ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      // NOTE: the data register is reset as well; its fields are visible on
      // the ports straight after reset, so they must come up known.
      data  <= '0;
    end else if (load && (!valid || accept)) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (accept) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_match_window_counter.sv
// Counts detector matches over fixed windows of accepted bits and publishes
// one {count, alarm} record per window, flagging dropped records in ovf.
module seq_match_window_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned WINDOW = DEF_WINDOW,
  parameter int unsigned CNT_W  = cnt_width(WINDOW),
  parameter int unsigned THRESH = DEF_THRESH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             in_valid,
  input  logic             det,
  input  logic             rec_ready,
  output logic             rec_valid,
  output logic [CNT_W-1:0] rec_count,
  output logic             rec_alarm,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  state_t           state, state_n;
  logic [CNT_W-1:0] bit_idx, bit_idx_n;
  logic [CNT_W-1:0] match_cnt, match_cnt_n;
  logic [CNT_W-1:0] close_cnt;
  logic             close;
  logic             drop;
  logic [CNT_W:0]   rec_data;

  // The closing bit's own det is folded in here rather than in match_cnt.
  assign close_cnt = match_cnt + CNT_W'(det);

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n     = state;
    bit_idx_n   = bit_idx;
    match_cnt_n = match_cnt;
    close       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bit_idx_n   = '0;
        match_cnt_n = '0;
        if (en) state_n = ST_COUNT;
      end
      ST_COUNT: begin
        if (!en) begin
          state_n     = ST_IDLE;
          bit_idx_n   = '0;
          match_cnt_n = '0;
        end else if (in_valid) begin
          if (bit_idx == LAST_IDX) begin
            close       = 1'b1;
            bit_idx_n   = '0;
            match_cnt_n = '0;
          end else begin
            bit_idx_n   = bit_idx + 1'b1;
            match_cnt_n = close_cnt;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      match_cnt <= '0;
    end else begin
      state     <= state_n;
      bit_idx   <= bit_idx_n;
      match_cnt <= match_cnt_n;
    end
  end

  seq_rec_hold #(
    .W(CNT_W + 1)
  ) u_rec_hold (
    .clk       (clk),
    .rstn      (rstn),
    .load      (close),
    .load_data ({(close_cnt >= THRESH_C), close_cnt}),
    .ready     (rec_ready),
    .valid     (rec_valid),
    .data      (rec_data),
    .drop      (drop)
  );

  assign rec_count = rec_data[CNT_W-1:0];
  assign rec_alarm = rec_data[CNT_W];

  // A drop on the same edge as a clear wins, so no loss goes unreported.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_seq_match_window_counter.sv
// Randomised and directed bench for seq_match_window_counter against a
// behavioural window/record model.
module tb_seq_match_window_counter;

  localparam int WINDOW = 16;
  localparam int THRESH = 4;
  localparam int CNT_W  = 5;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             en = 1'b0;
  logic             in_valid = 1'b0;
  logic             det = 1'b0;
  logic             rec_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             rec_valid;
  logic [CNT_W-1:0] rec_count;
  logic             rec_alarm;
  logic             ovf;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: whether a window is open, how far it has got, and the
  // record the consumer currently sees.
  bit m_open;
  int m_bits, m_hits;
  bit m_valid;
  int m_count;
  bit m_alarm;
  bit m_ovf;

  seq_match_window_counter #(
    .WINDOW(WINDOW),
    .CNT_W (CNT_W),
    .THRESH(THRESH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .in_valid (in_valid),
    .det      (det),
    .rec_ready(rec_ready),
    .rec_valid(rec_valid),
    .rec_count(rec_count),
    .rec_alarm(rec_alarm),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_bits = 0; m_hits = 0;
    m_valid = 0; m_count = 0; m_alarm = 0; m_ovf = 0;
  endtask

  task automatic compare_all();
    check("rec_valid", int'(rec_valid), int'(m_valid));
    check("rec_count", int'(rec_count), m_count);
    check("rec_alarm", int'(rec_alarm), int'(m_alarm));
    check("ovf", int'(ovf), int'(m_ovf));
  endtask

  // Apply one cycle of inputs, advance the model by one edge, then compare.
  task automatic step(input bit e, input bit iv, input bit d, input bit r, input bit c);
    bit closed, lost;
    int total;
    en = e; in_valid = iv; det = d; rec_ready = r; ovf_clr = c;
    @(posedge clk);
    closed = 0; lost = 0; total = 0;
    if (!m_open) begin
      m_open = e; m_bits = 0; m_hits = 0;
    end else if (!e) begin
      m_open = 0; m_bits = 0; m_hits = 0;
    end else if (iv) begin
      m_bits++;
      m_hits += int'(d);
      if (m_bits == WINDOW) begin
        closed = 1; total = m_hits; m_bits = 0; m_hits = 0;
      end
    end
    if (closed) begin
      if (m_valid && !r) lost = 1;
      else begin
        m_valid = 1; m_count = total; m_alarm = (total >= THRESH);
      end
    end else if (m_valid && r) m_valid = 0;
    if (lost) m_ovf = 1;
    else if (c) m_ovf = 0;
    #1;
    compare_all();
  endtask

  // Feed one full window of accepted bits; det on bit i set by mask[i].
  task automatic window(input logic [WINDOW-1:0] mask, input bit r);
    for (int i = 0; i < WINDOW; i++) step(1, 1, mask[i], r, 0);
  endtask

  task automatic do_reset();
    rstn = 0; en = 0; in_valid = 0; det = 0; rec_ready = 0; ovf_clr = 0;
    model_reset();
    repeat (4) @(posedge clk);
    #3 rstn = 1;
    #1;
  endtask

  initial begin
    logic [WINDOW-1:0] mask;

    do_reset();
    compare_all();
    check("reset_valid", int'(rec_valid), 0);
    check("reset_ovf", int'(ovf), 0);

    // Basic count: the enabling edge carries a valid det that must be ignored.
    step(1, 1, 1, 0, 0);
    mask = '0; mask[2] = 1; mask[5] = 1; mask[8] = 1; mask[11] = 1;
    for (int i = 0; i < WINDOW - 1; i++) step(1, 1, mask[i], 0, 0);
    check("basic_not_yet", int'(rec_valid), 0);
    step(1, 1, mask[WINDOW-1], 0, 0);
    check("basic_valid", int'(rec_valid), 1);
    check("basic_count", int'(rec_count), 4);
    check("basic_alarm", int'(rec_alarm), 1);
    step(1, 0, 0, 1, 0);

    // Gaps: det driven on invalid cycles only counts when qualified.
    mask = '0; mask[0] = 1; mask[9] = 1; mask[15] = 1;
    for (int i = 0; i < WINDOW; i++) begin
      step(1, 0, 1, 0, 0);
      step(1, 1, mask[i], 0, 0);
    end
    check("gap_count", int'(rec_count), 3);
    check("gap_alarm", int'(rec_alarm), 0);
    step(1, 0, 0, 1, 0);

    // Back-pressure across two closes, then clear and drain.
    window(16'h00ff, 0);
    window(16'h0001, 0);
    check("bp_ovf", int'(ovf), 1);
    check("bp_held", int'(rec_count), 8);
    step(1, 0, 0, 0, 1);
    check("bp_clr", int'(ovf), 0);
    step(1, 0, 0, 1, 0);
    check("bp_drain", int'(rec_valid), 0);

    // Close and accept on the same edge.
    window(16'h0003, 0);
    for (int i = 0; i < WINDOW - 1; i++) step(1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    check("simul_valid", int'(rec_valid), 1);
    check("simul_count", int'(rec_count), 16);
    check("simul_ovf", int'(ovf), 0);
    step(1, 0, 0, 1, 0);

    // Abort a partial window, then a clean all-zero window.
    for (int i = 0; i < 10; i++) step(1, 1, (i % 3) == 0 && i < 9, 0, 0);
    step(0, 1, 1, 0, 0);
    check("abort_norec", int'(rec_valid), 0);
    step(1, 0, 0, 0, 0);
    window('0, 0);
    check("abort_valid", int'(rec_valid), 1);
    check("abort_count", int'(rec_count), 0);

    // Async reset between edges with a record pending and ovf set.
    window(16'hffff, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0);
    #2 rstn = 0;
    #1;
    check("arst_valid", int'(rec_valid), 0);
    check("arst_ovf", int'(ovf), 0);
    check("arst_count", int'(rec_count), 0);
    model_reset();
    @(posedge clk);
    #3 rstn = 1;
    #1;
    step(1, 0, 0, 0, 0);
    window(16'h8421, 0);
    check("arst_next", int'(rec_count), 4);
    step(1, 0, 0, 1, 0);

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
           1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_match_window_counter.md
Name: seq_match_window_counter

Overview:
- Downstream consumer of the 110 Mealy sequence detector's `out` pulse.
- Counts detector matches over fixed windows of WINDOW accepted input bits.
- At each window close, emits one record (match count plus threshold alarm) on a valid/ready interface to the status/CSR logic.
- Flags records lost to back-pressure with a sticky overflow bit.

Parameters:
- WINDOW, 16: accepted bits per window; legal range 2..65535.
- CNT_W, 5: width of the match/bit counters; must equal clog2(WINDOW+1).
- THRESH, 4: a window with count >= THRESH raises rec_alarm; legal range 1..WINDOW.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  level enable; low abandons the current window.
- in_valid  input  1  the detector consumed a bit this cycle (qualifies det).
- det  input  1  detector Mealy output; sampled only when in_valid=1.
- rec_ready  input  1  consumer accepts the record.
- rec_valid  output  1  record held on rec_count/rec_alarm.
- rec_count  output  CNT_W  matches in the closed window.
- rec_alarm  output  1  rec_count >= THRESH.
- ovf  output  1  sticky: a closed window was dropped.
- ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; bit_idx=0; match_cnt=0; rec_valid=0; rec_count=0; rec_alarm=0; ovf=0. Reset mid-window discards all partial state.
- FSM has two states.
  - IDLE: counters held at 0. Goes to COUNT on the edge where en=1. The bit on that same edge is not counted; counting starts the next cycle.
  - COUNT: on each edge with in_valid=1:
    - bit_idx increments.
    - If det=1, match_cnt increments.
  - COUNT, on an edge with in_valid=1 and bit_idx==WINDOW-1 (window close):
    - close_cnt = match_cnt + det.
    - bit_idx and match_cnt return to 0; state stays COUNT.
  - COUNT with en=0 on any edge: go to IDLE, clear counters, no record. en takes priority over in_valid on that edge.
- det with in_valid=0 is ignored; a glitchy combinational det between edges has no effect.
- match_cnt cannot exceed WINDOW, so no saturation is needed. Counter widths are CNT_W; all compares are unsigned.
- Record register (one entry). At window close:
  - rec_valid=0: load record, rec_valid<=1.
  - rec_valid=1 and rec_ready=1 (handshake same edge): load new record, rec_valid stays 1, no overflow.
  - rec_valid=1 and rec_ready=0: keep old record unchanged, drop new, ovf<=1.
- Without a close, rec_valid&rec_ready clears rec_valid on that edge.
- rec_count and rec_alarm hold their values while rec_valid=0; the consumer ignores them then.
- Latency: rec_valid rises on the same edge that samples the window's last bit (registered, visible the following cycle).
- rec_alarm is registered together with rec_count: (close_cnt >= THRESH).
- ovf: set has priority over ovf_clr when both occur on the same edge; otherwise ovf_clr=1 clears it.
- rec_valid must stay stable until handshake; rec_count/rec_alarm must not change while rec_valid=1 and rec_ready=0.
- en=0 does not touch the record register or ovf; a pending record can still drain in IDLE.

Decomposition:
- Shared package seq_det_pkg holds:
  - state enum {ST_IDLE, ST_COUNT};
  - the default WINDOW/THRESH constants;
  - the CNT_W derivation function (clog2).
- One sub-module, seq_rec_hold: single-entry valid/ready hold register with overflow detect. Inputs: load, data, ready. Outputs: valid, data, drop pulse.
- Top level contains the FSM, the counters and ovf.

Test Plan:
- Basic count: reset 4 cycles, en=1, 16 in_valid bits with det=1 on bits 2,5,8,11 -> one record, rec_count=4, rec_alarm=1; rec_valid rises after bit 15's edge.
- Below threshold and gaps: 16 valid bits interleaved with in_valid=0 cycles, where det=1 is driven on invalid cycles, plus det on valid bits 0,9,15 -> rec_count=3, rec_alarm=0. Invalid-cycle det ignored; bit 15 det included.
- Back-pressure: rec_ready=0 across two full windows -> first record held unchanged, ovf=1 after second close. Then ovf_clr=1 -> ovf=0. rec_ready=1 -> handshake, rec_valid=0.
- Simultaneous close and accept: rec_ready=1 exactly on the closing edge of window 2 while window-1 record pending -> rec_valid stays 1, rec_count updates to window-2 value, ovf=0.
- Abort: en=0 after 10 bits with 3 dets, then en=1 and 16 bits with det=0 -> one record, rec_count=0, no partial record.
- Async reset mid-window: rstn=0 between edges with rec_valid=1 -> rec_valid, ovf and counters 0 immediately. After release, the next window counts from bit 0.
